enter_parking_lot: RTL and testbench

// - Entry-side controller of the 8-slot parking lot; counterpart of the exit-side slot decoder.
// - Tracks slot occupancy and allocates the lowest-numbered free slot to each arriving car.
// - Drives the entry gate and releases slots on exit requests.
// - Publishes park_location in the same one-cold format the exit side uses.

---
 rtl/enter_parking_lot_pkg.sv | 26 ++
 rtl/enter_parking_lot_slot_finder.sv | 23 ++
 rtl/enter_parking_lot.sv | 140 ++++++++++++++
 tb/tb_enter_parking_lot.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/enter_parking_lot_pkg.sv
// Shared constants, state encoding and helpers for the parking lot entry side.
// Imported by park_slot_finder and enter_parking_lot.
package enter_parking_lot_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    localparam logic [NUM_SLOTS-1:0] FULL_MASK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GATE    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Number of zero bits in an occupancy mask.
    function automatic logic [3:0] count_free(input logic [NUM_SLOTS-1:0] occ);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            c = c + {3'b000, ~occ[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/enter_parking_lot_slot_finder.sv
// Combinational priority encoder: lowest free slot in the occupancy mask.
// Ports: occupancy in; free_idx (lowest zero bit), any_free out.
module park_slot_finder
    import enter_parking_lot_pkg::*;
(
    input  logic [NUM_SLOTS-1:0] occupancy,
    output logic [SLOT_W-1:0]    free_idx,
    output logic                 any_free
);

    // Scan from the top down so the lowest free index is the last write.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occupancy[i]) begin
                free_idx = SLOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enter_parking_lot.sv
// Entry-side controller of the 8-slot parking lot: allocates slots, drives the gate, handles exits.
// Ports: clk, reset, entry_req, exit_valid, exit_number in; grant/deny/gate/status outputs.
module enter_parking_lot
    import enter_parking_lot_pkg::*;
#(
    parameter int GATE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_req,
    input  logic                 exit_valid,
    input  logic [SLOT_W-1:0]    exit_number,
    output logic [SLOT_W-1:0]    park_number,
    output logic [NUM_SLOTS-1:0] park_location,
    output logic                 entry_grant,
    output logic                 entry_denied,
    output logic                 gate_open,
    output logic                 exit_error,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [3:0]           free_count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [SLOT_W-1:0]    park_q, park_d;
    logic                 grant_q, grant_d;
    logic                 deny_q, deny_d;
    logic                 gate_q, gate_d;
    logic                 xerr_q, xerr_d;

    logic [SLOT_W-1:0]    free_idx;
    logic                 any_free;

    park_slot_finder u_finder (
        .occupancy (occ_q),
        .free_idx  (free_idx),
        .any_free  (any_free)
    );

    // Status is decoded straight from the occupancy register.
    assign full          = (occ_q == FULL_MASK);
    assign empty         = (occ_q == '0);
    assign free_count    = count_free(occ_q);
    assign occupancy     = occ_q;
    assign park_number   = park_q;
    assign park_location = ~(NUM_SLOTS'(1) << park_q);
    assign entry_grant   = grant_q;
    assign entry_denied  = deny_q;
    assign gate_open     = gate_q;
    assign exit_error    = xerr_q;

    wire do_grant = (state_q == ST_IDLE) && entry_req && !full && any_free;
    wire do_deny  = (state_q == ST_IDLE) && entry_req && full;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (do_grant)     state_d = ST_GATE;
                else if (do_deny) state_d = ST_RELEASE;
            end
            ST_GATE: begin
                if (cnt_q == '0)  state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!entry_req)   state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath / registered output logic.
    always_comb begin
        cnt_d   = cnt_q;
        occ_d   = occ_q;
        park_d  = park_q;
        gate_d  = gate_q;
        grant_d = 1'b0;
        deny_d  = 1'b0;
        xerr_d  = 1'b0;

        // Exits see the pre-edge occupancy; a slot being allocated this
        // cycle still reads as empty and flags an error.
        if (exit_valid) begin
            if (occ_q[exit_number]) occ_d[exit_number] = 1'b0;
            else                    xerr_d = 1'b1;
        end

        if (do_grant) begin
            occ_d[free_idx] = 1'b1;
            park_d  = free_idx;
            grant_d = 1'b1;
            gate_d  = 1'b1;
            cnt_d   = GATE_LOAD;
        end else if (do_deny) begin
            deny_d = 1'b1;
        end

        if (state_q == ST_GATE) begin
            if (cnt_q == '0) gate_d = 1'b0;
            else             cnt_d  = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            occ_q   <= '0;
            park_q  <= '0;
            grant_q <= 1'b0;
            deny_q  <= 1'b0;
            gate_q  <= 1'b0;
            xerr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            park_q  <= park_d;
            grant_q <= grant_d;
            deny_q  <= deny_d;
            gate_q  <= gate_d;
            xerr_q  <= xerr_d;
        end
    end

endmodule

// File: tb/tb_enter_parking_lot.sv
// Directed testbench for enter_parking_lot.
// Drives entries/exits/reset and compares against hand-computed values.
module tb_enter_parking_lot;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_valid = 1'b0;
    logic [2:0] exit_number = 3'd0;
    logic [2:0] park_number;
    logic [7:0] park_location;
    logic       entry_grant;
    logic       entry_denied;
    logic       gate_open;
    logic       exit_error;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;
    logic       empty;

    int vectors = 0;
    int miscompares = 0;

    enter_parking_lot #(.GATE_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_valid    (exit_valid),
        .exit_number   (exit_number),
        .park_number   (park_number),
        .park_location (park_location),
        .entry_grant   (entry_grant),
        .entry_denied  (entry_denied),
        .gate_open     (gate_open),
        .exit_error    (exit_error),
        .occupancy     (occupancy),
        .free_count    (free_count),
        .full          (full),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raise entry_req until grant or deny (bounded), drop it, then follow
    // the gate until it closes and the FSM is back in IDLE.
    task automatic do_entry(output logic g, output logic d, output logic [2:0] pn,
                            output logic [7:0] loc, output int gc, output int ng);
        g = 1'b0; d = 1'b0; pn = 3'd0; loc = 8'h00; gc = 0; ng = 0;
        entry_req = 1'b1;
        for (int i = 0; i < 8 && !g && !d; i++) begin
            tick();
            g = entry_grant;
            d = entry_denied;
        end
        pn  = park_number;
        loc = park_location;
        entry_req = 1'b0;
        for (int i = 0; i < 20 && gate_open; i++) begin
            gc++;
            if (entry_grant) ng++;
            tick();
        end
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (occupancy !== 8'h00) begin miscompares++; $display("FAIL reset_occ got %h want 00", occupancy); end
        vectors++;
        if (free_count !== 4'd8) begin miscompares++; $display("FAIL reset_free got %0d want 8", free_count); end
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_empty_full got %b%b want 10", empty, full); end
        vectors++;
        if (park_location !== 8'hFE) begin miscompares++; $display("FAIL reset_loc got %h want FE", park_location); end
        vectors++;
        if ({gate_open, entry_grant, entry_denied, exit_error, park_number} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_outs got %b%b%b%b %0d want 0000 0", gate_open, entry_grant, entry_denied, exit_error, park_number);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill;
        logic g, d; logic [2:0] pn; logic [7:0] loc; int gc, ng;
        for (int k = 0; k < 3; k++) begin
            do_entry(g, d, pn, loc, gc, ng);
            vectors++;
            if (g !== 1'b1 || pn !== 3'(k)) begin miscompares++; $display("FAIL fill_grant%0d got g=%b pn=%0d want g=1 pn=%0d", k, g, pn, k); end
            vectors++;
            if (gc !== 4) begin miscompares++; $display("FAIL fill_gate%0d got %0d cycles want 4", k, gc); end
            vectors++;
            if (ng !== 1) begin miscompares++; $display("FAIL fill_pulse%0d got %0d grant cycles want 1", k, ng); end
        end
        vectors++;
        if (occupancy !== 8'h07 || free_count !== 4'd5) begin
            miscompares++; $display("FAIL fill_occ got %h/%0d want 07/5", occupancy, free_count);
        end
    endtask

    task automatic test_reuse;
        logic g, d; logic [2:0] pn; logic [7:0] loc; int gc, ng;
        exit_valid = 1'b1; exit_number = 3'd1;
        tick();
        exit_valid = 1'b0;
        vectors++;
        if (occupancy !== 8'h05 || exit_error !== 1'b0) begin
            miscompares++; $display("FAIL reuse_exit got %h err=%b want 05 err=0", occupancy, exit_error);
        end
        do_entry(g, d, pn, loc, gc, ng);
        vectors++;
        if (g !== 1'b1 || pn !== 3'd1 || loc !== 8'hFD) begin
            miscompares++; $display("FAIL reuse_grant got g=%b pn=%0d loc=%h want 1 1 FD", g, pn, loc);
        end
        vectors++;
        if (occupancy !== 8'h07) begin miscompares++; $display("FAIL reuse_occ got %h want 07", occupancy); end
    endtask

    task automatic test_full;
        logic g, d; logic [2:0] pn; logic [7:0] loc; int gc, ng; int nd, ngate;
        for (int k = 3; k < 8; k++) begin
            do_entry(g, d, pn, loc, gc, ng);
            vectors++;
            if (g !== 1'b1 || pn !== 3'(k)) begin miscompares++; $display("FAIL full_fill%0d got g=%b pn=%0d want 1 %0d", k, g, pn, k); end
        end
        vectors++;
        if (full !== 1'b1 || free_count !== 4'd0 || occupancy !== 8'hFF) begin
            miscompares++; $display("FAIL full_flag got full=%b free=%0d occ=%h want 1 0 FF", full, free_count, occupancy);
        end
        nd = 0; ngate = 0;
        entry_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (entry_denied) nd++;
            if (gate_open || entry_grant) ngate++;
        end
        entry_req = 1'b0;
        tick();
        tick();
        vectors++;
        if (nd !== 1) begin miscompares++; $display("FAIL full_deny got %0d denies want 1", nd); end
        vectors++;
        if (ngate !== 0 || occupancy !== 8'hFF) begin
            miscompares++; $display("FAIL full_nogate got gate=%0d occ=%h want 0 FF", ngate, occupancy);
        end
    endtask

    task automatic test_simultaneous;
        logic g, d; logic [2:0] pn; logic [7:0] loc; int gc, ng;
        entry_req = 1'b1; exit_valid = 1'b1; exit_number = 3'd3;
        tick();
        exit_valid = 1'b0;
        vectors++;
        if (entry_denied !== 1'b1 || entry_grant !== 1'b0) begin
            miscompares++; $display("FAIL simul_deny got deny=%b grant=%b want 1 0", entry_denied, entry_grant);
        end
        vectors++;
        if (occupancy !== 8'hF7) begin miscompares++; $display("FAIL simul_occ got %h want F7", occupancy); end
        entry_req = 1'b0;
        tick();
        tick();
        do_entry(g, d, pn, loc, gc, ng);
        vectors++;
        if (g !== 1'b1 || pn !== 3'd3 || occupancy !== 8'hFF) begin
            miscompares++; $display("FAIL simul_reuse got g=%b pn=%0d occ=%h want 1 3 FF", g, pn, occupancy);
        end
    endtask

    task automatic test_errors_reset;
        logic g, d; logic [2:0] pn; logic [7:0] loc; int gc, ng;
        exit_valid = 1'b1; exit_number = 3'd5;
        tick();
        tick();
        exit_valid = 1'b0;
        vectors++;
        if (exit_error !== 1'b1 || occupancy !== 8'hDF) begin
            miscompares++; $display("FAIL err_pulse got err=%b occ=%h want 1 DF", exit_error, occupancy);
        end
        tick();
        vectors++;
        if (exit_error !== 1'b0) begin miscompares++; $display("FAIL err_width got %b want 0", exit_error); end

        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        vectors++;
        if (gate_open !== 1'b1 || park_number !== 3'd5) begin
            miscompares++; $display("FAIL gate_pre got gate=%b pn=%0d want 1 5", gate_open, park_number);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (gate_open !== 1'b0 || occupancy !== 8'h00) begin
            miscompares++; $display("FAIL async_reset got gate=%b occ=%h want 0 00", gate_open, occupancy);
        end
        tick();
        reset = 1'b0;
        tick();

        entry_req = 1'b1; exit_valid = 1'b1; exit_number = 3'd0;
        tick();
        exit_valid = 1'b0; entry_req = 1'b0;
        vectors++;
        if (entry_grant !== 1'b1 || exit_error !== 1'b1 || occupancy !== 8'h01 || park_number !== 3'd0) begin
            miscompares++;
            $display("FAIL grant_exit_same got g=%b err=%b occ=%h pn=%0d want 1 1 01 0", entry_grant, exit_error, occupancy, park_number);
        end
        for (int i = 0; i < 6; i++) tick();
        do_entry(g, d, pn, loc, gc, ng);
        vectors++;
        if (g !== 1'b1 || pn !== 3'd1 || gc !== 4) begin
            miscompares++; $display("FAIL post_reset got g=%b pn=%0d gate=%0d want 1 1 4", g, pn, gc);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_reuse();
        test_full();
        test_simultaneous();
        test_errors_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
